cla4_resp_checker: RTL and testbench
====================================

Name: cla4_resp_checker

Overview:
- Hardware response checker: the receiving end of the adder stimulus stream.
- Accepts operand/result vectors from a 4-bit carry-lookahead adder (DUT outputs S, Co, PG, GG) over a valid/ready handshake.
- Recomputes the expected result, counts pass/fail over a fixed vector budget and latches the first mismatch.
- Used in the adder bench and in on-chip self-test, replacing file-based result logging.

Parameters:
- WIDTH, 4, operand width; PG/GG checking is defined for the single 4-bit group.
- NVEC, 10, vectors per run; the run ends after NVEC accepted vectors.
- CNT_W, 8, width of the vector and error counters; NVEC must be < 2**CNT_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- in_valid  in  1  vector present on a/b/ci/dut_*
- in_ready  out  1  checker accepts a vector this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry in
- dut_s  in  WIDTH  DUT sum
- dut_co  in  1  DUT carry out
- dut_pg  in  1  DUT group propagate
- dut_gg  in  1  DUT group generate
- busy  out  1  run in progress
- done  out  1  run complete, held until start or rst
- pass  out  1  valid when done=1; 1 iff err_cnt==0
- vec_cnt  out  CNT_W  vectors compared so far
- err_cnt  out  CNT_W  mismatching vectors, saturates at all-ones
- fail_idx  out  CNT_W  index (0-based) of the first failing vector
- fail_exp  out  WIDTH+3  expected {co,pg,gg,s} of the first failing vector
- fail_got  out  WIDTH+3  DUT {co,pg,gg,s} of the first failing vector

Behaviour:
- Reset: state IDLE; in_ready=0, busy=0, done=0, pass=0; all counters and fail_* = 0.
- FSM states:
  - IDLE: start -> RUN; clear counters, fail_* and the first-fail flag.
  - RUN: busy=1; in_ready=1 while accepted count < NVEC.
    - Accept occurs on in_valid && in_ready.
    - When accepted count reaches NVEC, in_ready drops the next cycle and the state goes to DRAIN.
  - DRAIN: waits one cycle for the last compare to retire -> DONE.
  - DONE: done=1, busy=0, in_ready=0; start -> RUN with a fresh clear.
- Pipeline, 2 stages:
  - Stage 1 registers the accepted vector.
  - Stage 2 compares and updates counters.
  - vec_cnt/err_cnt reflect an accepted vector 2 cycles after acceptance.
  - done asserts the cycle after the last vector's update, so it is 3 cycles after the last accept.
- Expected values, with p_i=a_i^b_i and g_i=a_i&b_i:
  - {co,s} = a + b + ci, computed at WIDTH+1 bits with no truncation.
  - pg = &p.
  - gg = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
- Mismatch: any of the 7 compared bits differs.
  - err_cnt increments by 1, saturating at all-ones.
  - On the first mismatch of a run, fail_idx, fail_exp and fail_got load and then hold.
- pass is a register: 1 in DONE iff err_cnt==0; 0 in every other state.
- start while in RUN/DRAIN is ignored.
- in_valid while in_ready=0 is ignored; no vector is consumed.
- rst mid-run aborts the run immediately to reset values; in-flight pipeline contents are discarded.
- No gaps are required: back-to-back valid vectors are accepted at 1 per cycle.

Decomposition:
- Package cla4_chk_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - the result-field packing order {co,pg,gg,s}
  - the function computing the expected {co,pg,gg,s} from a, b, ci
- One sub-module, cla4_ref_model: combinational golden adder plus PG/GG, instantiated in stage 2.

Test Plan:
- Reset, then start, then NVEC=10 correct vectors including a=4'hF, b=4'h1, ci=0 -> expect {co=1, s=4'h0, pg=0, gg=1}. Required: pass=1, err_cnt=0, vec_cnt=10, done 3 cycles after the last accept.
- a=4'h5, b=4'hA, ci=1 with correct DUT values -> expect s=4'h0, co=1, pg=1, gg=0, and no error. Separately, vector 3 has dut_s forced to 4'h1 -> err_cnt=1, fail_idx=3, fail_exp={1,1,0,4'h0}, fail_got={1,1,0,4'h1}, pass=0.
- Two failing vectors, at index 2 and index 7 -> err_cnt=2 and fail_idx stays 2.
- in_valid held high for 15 cycles -> exactly 10 vectors accepted; in_ready=0 from the 11th cycle on; vec_cnt=10.
- rst asserted after 4 accepts -> next cycle all outputs at reset values; a new start runs a clean 10-vector pass.
- start pulsed mid-RUN -> no effect; start pulsed in DONE -> counters clear and a second run completes.

Source files
------------

// File: rtl/cla4_chk_pkg.sv
// Shared types and the golden result function for the 4-bit CLA response checker.
// Result fields are always packed as {co, pg, gg, s}.
package cla4_chk_pkg;

   localparam int CLA_W = 4;
   localparam int RES_W = CLA_W + 3;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   typedef struct packed {
      logic             co;
      logic             pg;
      logic             gg;
      logic [CLA_W-1:0] s;
   } res_t;

   typedef struct packed {
      logic [CLA_W-1:0] a;
      logic [CLA_W-1:0] b;
      logic             ci;
      res_t             got;
   } vec_t;

   function automatic res_t cla_expect(input logic [CLA_W-1:0] a,
                                       input logic [CLA_W-1:0] b,
                                       input logic             ci);
      res_t             r;
      logic [CLA_W-1:0] p;
      logic [CLA_W-1:0] g;
      logic [CLA_W:0]   sum;
      logic             gg;
      p   = a ^ b;
      g   = a & b;
      sum = {1'b0, a} + {1'b0, b} + {{CLA_W{1'b0}}, ci};
      // Ripple the group generate from bit 0 up: gg_i = g_i | p_i & gg_(i-1)
      gg  = 1'b0;
      for (int i = 0; i < CLA_W; i++) gg = g[i] | (p[i] & gg);
      r.co = sum[CLA_W];
      r.s  = sum[CLA_W-1:0];
      r.pg = &p;
      r.gg = gg;
      return r;
   endfunction

endpackage

// File: rtl/cla4_resp_checker_if.sv
// Vector stream from the adder under test into the response checker.
interface cla4_resp_checker_if #(
   parameter int WIDTH = 4
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic [WIDTH-1:0] dut_s;
   logic             dut_co;
   logic             dut_pg;
   logic             dut_gg;

   modport master (output in_valid, a, b, ci, dut_s, dut_co, dut_pg, dut_gg,
                   input  in_ready);
   modport slave  (input  in_valid, a, b, ci, dut_s, dut_co, dut_pg, dut_gg,
                   output in_ready);
endinterface

// File: rtl/cla4_ref_model.sv
// Combinational golden 4-bit adder with group propagate/generate.
module cla4_ref_model
   import cla4_chk_pkg::*;
(
   input  logic [CLA_W-1:0] a,
   input  logic [CLA_W-1:0] b,
   input  logic             ci,
   output res_t             exp_res
);
   always_comb exp_res = cla_expect(a, b, ci);
endmodule

// File: rtl/cla4_resp_checker.sv
// Response checker: accepts NVEC adder result vectors, recomputes them,
// counts errors and latches the first mismatch. Two-stage register/compare pipe.
module cla4_resp_checker
   import cla4_chk_pkg::*;
#(
   parameter int WIDTH = CLA_W,
   parameter int NVEC  = 10,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   cla4_resp_checker_if.slave vif,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   vec_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [CNT_W-1:0]   fail_idx,
   output logic [WIDTH+2:0]   fail_exp,
   output logic [WIDTH+2:0]   fail_got
);
   localparam logic [CNT_W-1:0] NVEC_C  = CNT_W'(NVEC);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] fail_idx_q, fail_idx_d;
   logic             fail_seen_q, fail_seen_d;
   res_t             fail_exp_q, fail_exp_d;
   res_t             fail_got_q, fail_got_d;
   logic             s1_vld_q, s1_vld_d;
   vec_t             s1_vec_q, s1_vec_d;

   res_t             exp_res;
   logic             accept;
   logic             mismatch;

   cla4_ref_model u_ref (
      .a       (s1_vec_q.a),
      .b       (s1_vec_q.b),
      .ci      (s1_vec_q.ci),
      .exp_res (exp_res)
   );

   always_comb begin
      accept      = vif.in_valid && in_ready_q;
      mismatch    = s1_vld_q && (exp_res != s1_vec_q.got);

      state_d     = state_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      acc_cnt_d   = acc_cnt_q;
      vec_cnt_d   = vec_cnt_q;
      err_cnt_d   = err_cnt_q;
      fail_idx_d  = fail_idx_q;
      fail_seen_d = fail_seen_q;
      fail_exp_d  = fail_exp_q;
      fail_got_d  = fail_got_q;
      s1_vld_d    = accept;
      s1_vec_d    = s1_vec_q;

      if (accept) begin
         s1_vec_d.a      = vif.a;
         s1_vec_d.b      = vif.b;
         s1_vec_d.ci     = vif.ci;
         s1_vec_d.got.co = vif.dut_co;
         s1_vec_d.got.pg = vif.dut_pg;
         s1_vec_d.got.gg = vif.dut_gg;
         s1_vec_d.got.s  = vif.dut_s;
      end

      // Stage 2: vec_cnt_q is the 0-based index of the vector being compared
      if (s1_vld_q) vec_cnt_d = vec_cnt_q + 1'b1;
      if (mismatch) begin
         if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
         if (!fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_idx_d  = vec_cnt_q;
            fail_exp_d  = exp_res;
            fail_got_d  = s1_vec_q.got;
         end
      end

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = RUN;
               in_ready_d  = (NVEC_C != '0);
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               acc_cnt_d   = '0;
               vec_cnt_d   = '0;
               err_cnt_d   = '0;
               fail_idx_d  = '0;
               fail_seen_d = 1'b0;
               fail_exp_d  = '0;
               fail_got_d  = '0;
            end
         end
         RUN: begin
            if (accept) acc_cnt_d = acc_cnt_q + 1'b1;
            in_ready_d = (acc_cnt_d < NVEC_C);
            // Leave one cycle after the last accept so it reaches stage 2 first
            if (acc_cnt_q == NVEC_C) state_d = DRAIN;
         end
         DRAIN: begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         acc_cnt_q   <= '0;
         vec_cnt_q   <= '0;
         err_cnt_q   <= '0;
         fail_idx_q  <= '0;
         fail_seen_q <= 1'b0;
         fail_exp_q  <= '0;
         fail_got_q  <= '0;
         s1_vld_q    <= 1'b0;
         s1_vec_q    <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         acc_cnt_q   <= acc_cnt_d;
         vec_cnt_q   <= vec_cnt_d;
         err_cnt_q   <= err_cnt_d;
         fail_idx_q  <= fail_idx_d;
         fail_seen_q <= fail_seen_d;
         fail_exp_q  <= fail_exp_d;
         fail_got_q  <= fail_got_d;
         s1_vld_q    <= s1_vld_d;
         s1_vec_q    <= s1_vec_d;
      end
   end

   assign vif.in_ready = in_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign vec_cnt      = vec_cnt_q;
   assign err_cnt      = err_cnt_q;
   assign fail_idx     = fail_idx_q;
   assign fail_exp     = fail_exp_q;
   assign fail_got     = fail_got_q;

endmodule

// File: tb/tb_cla4_resp_checker.sv
// Directed bench for cla4_resp_checker with an accept-time scoreboard of counter values.
module tb_cla4_resp_checker;
   localparam int W  = 4;
   localparam int NV = 10;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done, pass;
   logic [CW-1:0] vec_cnt, err_cnt, fail_idx;
   logic [W+2:0]  fail_exp, fail_got;

   cla4_resp_checker_if #(.WIDTH(W)) vif ();

   cla4_resp_checker #(.WIDTH(W), .NVEC(NV), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .vif      (vif),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .vec_cnt  (vec_cnt),
      .err_cnt  (err_cnt),
      .fail_idx (fail_idx),
      .fail_exp (fail_exp),
      .fail_got (fail_got)
   );

   always #5 clk = ~clk;

   typedef struct {int due; int vec; int err;} sb_t;
   sb_t sb[$];

   int         checks = 0;
   int         passed = 0;
   int         cyc = 0;
   int         last_acc = 0;
   int         n_acc = 0;
   int         m_vec, m_err, m_idx;
   bit         m_seen;
   logic [6:0] m_exp, m_got;

   // Expected {co,pg,gg,s} written straight from the adder equations
   function automatic logic [6:0] ref7(input logic [3:0] a, input logic [3:0] b, input logic ci);
      logic [4:0] sum;
      logic [3:0] p, g;
      logic       pg, gg;
      sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
      p   = a ^ b;
      g   = a & b;
      pg  = p[0] & p[1] & p[2] & p[3];
      gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return {sum[4], pg, gg, sum[3:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic m_clear();
      m_vec = 0; m_err = 0; m_idx = 0; m_seen = 0; m_exp = '0; m_got = '0; n_acc = 0;
   endtask

   task automatic tick();
      logic       acc, rs;
      logic [6:0] e, g;
      sb_t        ent;
      rs  = rst;
      acc = vif.in_valid && vif.in_ready && !rst;
      e   = ref7(vif.a, vif.b, vif.ci);
      g   = {vif.dut_co, vif.dut_pg, vif.dut_gg, vif.dut_s};
      @(posedge clk);
      cyc++;
      #1;
      if (rs) begin
         sb.delete();
         m_clear();
      end else begin
         while (sb.size() > 0 && sb[0].due == cyc) begin
            ent = sb.pop_front();
            chk("sb_vec_cnt", vec_cnt, ent.vec);
            chk("sb_err_cnt", err_cnt, ent.err);
         end
         if (acc) begin
            if (e != g) begin
               if (!m_seen) begin
                  m_seen = 1; m_idx = m_vec; m_exp = e; m_got = g;
               end
               if (m_err != 255) m_err++;
            end
            m_vec++;
            n_acc++;
            last_acc = cyc;
            ent.due = cyc + 1; ent.vec = m_vec; ent.err = m_err;
            sb.push_back(ent);
         end
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic [6:0] flip);
      logic [6:0] r;
      r = ref7(a, b, ci) ^ flip;
      vif.a = a; vif.b = b; vif.ci = ci;
      {vif.dut_co, vif.dut_pg, vif.dut_gg, vif.dut_s} = r;
      vif.in_valid = 1'b1;
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic [6:0] flip);
      bit ok;
      drive(a, b, ci, flip);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = vif.in_ready;
         tick();
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_start(input string tag);
      m_clear();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_start_vec"}, vec_cnt, 0);
      chk({tag, "_start_err"}, err_cnt, 0);
      chk({tag, "_start_busy"}, busy, 1);
      chk({tag, "_start_rdy"}, vif.in_ready, 1);
      chk({tag, "_start_done"}, done, 0);
   endtask

   task automatic wait_done(input string tag, input bit check_lat);
      int n;
      vif.in_valid = 1'b0;
      n = 0;
      while (!done && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, done, 1);
      if (check_lat) chk({tag, "_done_lat"}, cyc - last_acc, 2);
      chk({tag, "_vec"}, vec_cnt, m_vec);
      chk({tag, "_err"}, err_cnt, m_err);
      chk({tag, "_pass"}, pass, (m_err == 0));
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rdy"}, vif.in_ready, 0);
      chk({tag, "_fidx"}, fail_idx, m_idx);
      chk({tag, "_fexp"}, fail_exp, m_exp);
      chk({tag, "_fgot"}, fail_got, m_got);
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   task automatic rnd_send();
      send(4'($urandom()), 4'($urandom()), 1'($urandom()), 7'h00);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      vif.in_valid = 1'b0; vif.a = '0; vif.b = '0; vif.ci = 1'b0;
      vif.dut_s = '0; vif.dut_co = 1'b0; vif.dut_pg = 1'b0; vif.dut_gg = 1'b0;
      m_clear();
      tick(); tick();
      rst = 1'b0;
      chk("rst_rdy", vif.in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_vec", vec_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_fail", {fail_idx, fail_exp, fail_got}, 0);

      // Run 1: all correct, includes F+1+0
      do_start("t1");
      for (int i = 0; i < NV; i++) begin
         if (i == 4) send(4'hF, 4'h1, 1'b0, 7'h00);
         else rnd_send();
      end
      wait_done("t1", 1);
      chk("t1_pass_c", pass, 1);
      chk("t1_vec_c", vec_cnt, 10);

      // Run 2 (start from DONE): 5+A+1 correct at 0, sum corrupted at 3
      do_start("t2");
      for (int i = 0; i < NV; i++) begin
         if (i == 0) send(4'h5, 4'hA, 1'b1, 7'h00);
         else if (i == 3) send(4'h5, 4'hA, 1'b1, 7'h01);
         else rnd_send();
      end
      wait_done("t2", 1);
      chk("t2_err_c", err_cnt, 1);
      chk("t2_fidx_c", fail_idx, 3);
      chk("t2_fexp_c", fail_exp, 7'b1100000);
      chk("t2_fgot_c", fail_got, 7'b1100001);
      chk("t2_pass_c", pass, 0);

      // Run 3: failures at 2 (co) and 7 (gg)
      do_start("t3");
      for (int i = 0; i < NV; i++) begin
         if (i == 2) send(4'($urandom()), 4'($urandom()), 1'b0, 7'h40);
         else if (i == 7) send(4'($urandom()), 4'($urandom()), 1'b1, 7'h10);
         else rnd_send();
      end
      wait_done("t3", 1);
      chk("t3_err_c", err_cnt, 2);
      chk("t3_fidx_c", fail_idx, 2);

      // Run 4: valid held 15 cycles, start pulsed mid-run
      do_start("t4");
      for (int i = 0; i < 15; i++) begin
         drive(4'($urandom()), 4'($urandom()), 1'($urandom()), 7'h00);
         if (i == 5) start = 1'b1;
         if (i == 10) chk("t4_rdy_low_11th", vif.in_ready, 0);
         tick();
         start = 1'b0;
         if (i == 6) chk("t4_busy_after_start", busy, 1);
      end
      chk("t4_n_acc", n_acc, 10);
      wait_done("t4", 0);
      chk("t4_vec_c", vec_cnt, 10);

      // Run 5: reset after 4 accepts, then a clean run
      do_start("t5");
      for (int i = 0; i < 4; i++) begin
         if (i == 1) send(4'h3, 4'h4, 1'b0, 7'h20);
         else rnd_send();
      end
      vif.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_rdy", vif.in_ready, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_done", done, 0);
      chk("t5_rst_pass", pass, 0);
      chk("t5_rst_vec", vec_cnt, 0);
      chk("t5_rst_err", err_cnt, 0);
      chk("t5_rst_fail", {fail_idx, fail_exp, fail_got}, 0);
      tick();
      chk("t5_idle_vec", vec_cnt, 0);
      do_start("t5b");
      for (int i = 0; i < NV; i++) rnd_send();
      wait_done("t5b", 1);
      chk("t5b_pass_c", pass, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
